// File: rtl/mips_mem_pkg.sv
// Shared encodings and lane helpers for the MIPS MEM stage.
// Size codes, FSM states, and byte-lane select/extend functions.
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    // Size code 3 behaves like a word access throughout.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        return ((size == SZ_HALF) && lane[0]) || (size[1] && (lane != 2'b00));
    endfunction

    function automatic logic [3:0] store_lanes(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] d;
        case (size)
            SZ_BYTE: d = {4{data[7:0]}};
            SZ_HALF: d = {2{data[15:0]}};
            default: d = data;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] size, input logic is_unsigned);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = is_unsigned ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = is_unsigned ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_stage_data_ram.sv
// Single-port synchronous word RAM with per-byte write enables and a
// registered read port. Contents are not reset.
module data_ram #(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [3:0]                     be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM pipeline stage: multi-cycle byte/half/word loads and stores
// against an internal data RAM, pipeline stall control and branch resolve.
module mem_stage
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LAT         = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        Branch,
    input  logic        zero,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    input  logic [31:0] total_alu_out,
    input  logic [31:0] rfile_rd2,
    output logic        PCSrc,
    output logic [31:0] mem_rd_data,
    output logic        done,
    output logic        stall,
    output logic        misalign
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    state_t        state, state_next;
    logic [2:0]    count;
    logic [AW+1:0] addr_q;
    logic [31:0]   data_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic          write_q;

    logic          req, bad, start, access;
    logic          ram_we;
    logic [3:0]    ram_be;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata, ram_rdata;
    logic          unused_addr_hi;

    assign unused_addr_hi = ^total_alu_out[31:AW+2];

    always_comb begin
        req        = MemRead | MemWrite;
        bad        = is_misaligned(size, total_alu_out[1:0]);
        start      = (state == IDLE) && req && !bad;
        access     = (state == WAIT) && (count == '0);
        misalign   = (state == IDLE) && req && bad;
        stall      = start || (state == WAIT);
        done       = (state == RESP);
        PCSrc      = Branch & zero;
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = WAIT;
            WAIT:    if (count == '0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            write_q     <= 1'b0;
            mem_rd_data <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                count   <= 3'(LAT - 1);
                addr_q  <= total_alu_out[AW+1:0];
                data_q  <= rfile_rd2;
                size_q  <= size;
                uns_q   <= ld_unsigned;
                write_q <= MemWrite;
            end else if ((state == WAIT) && (count != '0)) begin
                count <= count - 3'd1;
            end
            if (access) begin
                mem_rd_data <= write_q ? '0 : load_extend(ram_rdata, addr_q[1:0], size_q, uns_q);
            end
        end
    end

    // The RAM read register is fed the live address in IDLE so that the word
    // is already available during WAIT even when LAT is 1.
    always_comb begin
        ram_addr  = (state == IDLE) ? total_alu_out[AW+1:2] : addr_q[AW+1:2];
        ram_we    = access && write_q;
        ram_be    = store_lanes(size_q, addr_q[1:0]);
        ram_wdata = store_data(size_q, data_q);
    end

    data_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule
